boot_image_streamer: RTL and testbench

- Upstream feeder of the Processor packet-in port.
- Reads a boot image from a synchronous memory and emits it as the Processor's boot packet sequence: body length, program body words, epilogue, sleep, countdown.
- Replaces bench-side hard-coded packet sequencing, so boot can be driven from hardware (e.g. a host DMA'd image).

---
 rtl/boot_image_streamer.sv | 248 ++++++++++++++++++++++++
 tb/tb_boot_image_streamer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_image_streamer.sv
// Streams a boot image from synchronous memory as Processor boot packets: length, 4P body words, epilogue, sleep, countdown.
// First packet 2 cycles after start (3 with BOOT_IMAGE_STREAMER_CHECKSUM_EN, which also checks the body sum against word 0); ready low holds the packet.
module boot_image_streamer #(
  parameter int MEM_ADDR_W       = 11,
  parameter int DATA_W           = 16,
  parameter int PKT_ADDR_W       = 11,
  parameter int MAX_PROGRAM_SIZE = 1024,
  parameter int EPILOGUE_DATA    = 4,
  parameter int SLEEP_DATA       = 4,
  parameter int COUNTDOWN_DATA   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] image_base,
  output logic                  mem_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     packet_out_data,
  output logic [PKT_ADDR_W-1:0] packet_out_address,
  output logic                  packet_out_valid,
  input  logic                  packet_out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     checksum
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] RD_LEN = 4'd1;
  localparam logic [3:0] LEN    = 4'd2;
  localparam logic [3:0] BODY   = 4'd3;
  localparam logic [3:0] EPI    = 4'd4;
  localparam logic [3:0] SLEEP  = 4'd5;
  localparam logic [3:0] CNT    = 4'd6;
  localparam logic [3:0] DONE   = 4'd7;
  localparam logic [3:0] ERROR  = 4'd8;
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
  localparam logic [3:0] RD_SUM = 4'd9;
  localparam logic [3:0] FIRST_RD = RD_SUM;
  localparam logic [MEM_ADDR_W-1:0] FIRST_OFS = '0;
`else
  localparam logic [3:0] FIRST_RD = RD_LEN;
  localparam logic [MEM_ADDR_W-1:0] FIRST_OFS = MEM_ADDR_W'(1);
`endif

  logic [3:0]            state;
  logic [MEM_ADDR_W-1:0] base_q;
  logic [DATA_W-1:0]     p_q;
  logic [15:0]           rd_cnt;
  logic [15:0]           tx_cnt;
  logic [DATA_W-1:0]     skid0;
  logic [DATA_W-1:0]     skid1;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  done_q;
  logic                  error_q;
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0]     sum_q;
  logic [DATA_W-1:0]     sum_ref;
`endif

  logic                  idle_like;
  logic                  bad_len;
  logic                  xfer;
  logic                  body_pop;
  logic                  last_body;
  logic                  space_ok;
  logic                  body_rd;
  logic [15:0]           nwords;
  logic [MEM_ADDR_W-1:0] body_addr;

  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign bad_len   = (mem_rdata == '0) || (32'(mem_rdata) > MAX_PROGRAM_SIZE);
  assign nwords    = 16'({p_q, 2'b00});
  assign xfer      = packet_out_valid && packet_out_ready;
  assign body_pop  = (state == BODY) && xfer;
  assign last_body = body_pop && (tx_cnt == nwords - 16'd1);
  // A slot is free for the returning word if the pop this cycle makes room for it.
  assign space_ok  = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, body_pop});
  // Word 0 of the body is fetched speculatively while the length is decoded, so the body follows the length packet without a bubble.
  assign body_rd   = (state == RD_LEN) ||
                     (((state == LEN) || (state == BODY)) && (rd_cnt != nwords) && space_ok);
  assign body_addr = base_q + MEM_ADDR_W'(rd_cnt + 16'd2);

  assign busy     = !idle_like;
  assign done     = done_q;
  assign error    = error_q;
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    if (idle_like && start) begin
      mem_en   = 1'b1;
      mem_addr = image_base + FIRST_OFS;
    end
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
    else if (state == RD_SUM) begin
      mem_en   = 1'b1;
      mem_addr = base_q + MEM_ADDR_W'(1);
    end
`endif
    else if (body_rd) begin
      mem_en   = 1'b1;
      mem_addr = body_addr;
    end
  end

  always_comb begin
    packet_out_valid   = 1'b0;
    packet_out_data    = '0;
    packet_out_address = '0;
    case (state)
      LEN: begin
        packet_out_valid = 1'b1;
        packet_out_data  = p_q;
      end
      BODY: begin
        packet_out_valid   = (occ != 2'd0);
        packet_out_data    = skid0;
        packet_out_address = PKT_ADDR_W'(1);
      end
      EPI: begin
        packet_out_valid = 1'b1;
        packet_out_data  = DATA_W'(EPILOGUE_DATA);
      end
      SLEEP: begin
        packet_out_valid = 1'b1;
        packet_out_data  = DATA_W'(SLEEP_DATA);
      end
      CNT: begin
        packet_out_valid = 1'b1;
        packet_out_data  = DATA_W'(COUNTDOWN_DATA);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      base_q   <= '0;
      p_q      <= '0;
      rd_cnt   <= '0;
      tx_cnt   <= '0;
      skid0    <= '0;
      skid1    <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
      sum_q    <= '0;
      sum_ref  <= '0;
`endif
    end else begin
      inflight <= body_rd;
      if (body_rd)  rd_cnt <= rd_cnt + 16'd1;
      if (body_pop) tx_cnt <= tx_cnt + 16'd1;
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
      if (body_pop) sum_q <= sum_q + skid0;
`endif
      case ({inflight, body_pop})
        2'b10: begin
          if (occ == 2'd0) skid0 <= mem_rdata;
          else             skid1 <= mem_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= mem_rdata;
          end else begin
            skid0 <= skid1;
            skid1 <= mem_rdata;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state   <= FIRST_RD;
            base_q  <= image_base;
            rd_cnt  <= '0;
            tx_cnt  <= '0;
            occ     <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
        RD_SUM: begin
          sum_ref <= mem_rdata;
          state   <= RD_LEN;
        end
`endif
        RD_LEN: begin
          p_q <= mem_rdata;
          if (bad_len) begin
            state    <= ERROR;
            error_q  <= 1'b1;
            inflight <= 1'b0;
          end else begin
            state <= LEN;
          end
        end
        LEN:   if (xfer) state <= BODY;
        BODY: begin
          if (last_body) begin
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
            if (sum_q + skid0 != sum_ref) begin
              state   <= ERROR;
              error_q <= 1'b1;
            end else begin
              state <= EPI;
            end
`else
            state <= EPI;
`endif
          end
        end
        EPI:   if (xfer) state <= SLEEP;
        SLEEP: if (xfer) state <= CNT;
        CNT: begin
          if (xfer) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_image_streamer.sv
// Bench for boot_image_streamer: random images in a behavioural memory, expected packet list built from the image layout rules.
`timescale 1ns/1ps
module tb_boot_image_streamer;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int PW   = 11;
  localparam int MAXP = 1024;
  localparam int MEMW = 1 << AW;
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [31:0]   cyc;
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic [AW-1:0] image_base = '0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] packet_out_data;
  logic [PW-1:0] packet_out_address;
  logic          packet_out_valid;
  logic          busy, done, error;
  logic [DW-1:0] checksum;

  logic [DW-1:0]      mem [0:MEMW-1];
  int                 cyc = 0;
  int                 rdy_mode = 0;
  int                 rdy_base = 0;
  int                 checks = 0;
  int                 errors = 0;
  int                 stall_viol = 0;
  int                 log_base = 0;
  int                 start_cyc = 0;
  int                 end_cyc = 0;
  logic               timed_out = 1'b0;
  pkt_t               log_q[$];
  logic [PW+DW-1:0]   exp_q[$];
  logic               exp_err = 1'b0;
  logic [DW-1:0]      exp_sum = '0;
  logic               prev_stall = 1'b0;
  logic [PW-1:0]      prev_addr = '0;
  logic [DW-1:0]      prev_data = '0;

  boot_image_streamer dut (
    .clock(clk), .reset(rst_n), .start(start), .image_base(image_base),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .packet_out_data(packet_out_data), .packet_out_address(packet_out_address),
    .packet_out_valid(packet_out_valid), .packet_out_ready(ready),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       ready = (((cyc - rdy_base) % 4) == 0) || (((cyc - rdy_base) % 4) == 3);
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b1;
    endcase
  end

  // Transfer log plus a watch on anything changing while a packet is stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (packet_out_valid !== 1'b1 || packet_out_address !== prev_addr ||
                         packet_out_data !== prev_data))
        stall_viol++;
      if (packet_out_valid === 1'b1 && ready)
        log_q.push_back({32'(cyc), packet_out_address, packet_out_data});
      prev_stall = packet_out_valid && !ready;
      prev_addr  = packet_out_address;
      prev_data  = packet_out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic load_image(input int base, input int p, input int sum_off);
    logic [DW-1:0] s;
    s = '0;
    if (p >= 1 && p <= MAXP)
      for (int i = 0; i < 4 * p; i++) mem[(base + 2 + i) % MEMW] = DW'($urandom);
    mem[(base + 1) % MEMW] = DW'(p);
    if (p >= 1 && p <= MAXP)
      for (int i = 0; i < 4 * p; i++) s += mem[(base + 2 + i) % MEMW];
    mem[base % MEMW] = s + DW'(sum_off);
  endtask

  task automatic model_image(input int base);
    int            p;
    logic [DW-1:0] s;
    logic [DW-1:0] w;
    exp_q.delete();
    exp_err = 1'b0;
    s = '0;
    p = int'(mem[(base + 1) % MEMW]);
    exp_sum = '0;
    if (p == 0 || p > MAXP) begin
      exp_err = 1'b1;
      return;
    end
    exp_q.push_back({PW'(0), DW'(p)});
    for (int i = 0; i < 4 * p; i++) begin
      w = mem[(base + 2 + i) % MEMW];
      exp_q.push_back({PW'(1), w});
      s += w;
    end
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
    exp_sum = s;
    if (s != mem[base % MEMW]) begin
      exp_err = 1'b1;
      return;
    end
`endif
    repeat (3) exp_q.push_back({PW'(0), DW'(4)});
  endtask

  task automatic start_stream(input int base);
    image_base = AW'(base);
    log_base = log_q.size();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) begin
        timed_out = 1'b0;
        end_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (packet_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", packet_out_valid); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, error}); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem got %b/%h want 0/0", mem_en, mem_addr); end
    checks++; if (packet_out_data !== '0 || packet_out_address !== '0 || checksum !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", packet_out_data, packet_out_address, checksum); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({packet_out_valid, busy, done, error} !== 4'b0000) begin errors++; $display("FAIL idle_after_reset got %b want 0000", {packet_out_valid, busy, done, error}); end
  endtask

  task automatic test_nominal();
    rdy_mode = 0;
    load_image(0, 7, 0);
    model_image(0);
    start_stream(0);
    wait_end(100);
    checks++; if (timed_out) begin errors++; $display("FAIL nominal_timeout got timeout want end"); end
    checks++; if (log_q.size() - log_base != exp_q.size()) begin errors++; $display("FAIL nominal_count got %0d want %0d", log_q.size() - log_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++;
      if ({log_q[log_base + i].addr, log_q[log_base + i].data} !== exp_q[i] ||
          int'(log_q[log_base + i].cyc) != start_cyc + LAT + i) begin
        errors++;
        $display("FAIL nominal_pkt%0d got %h@%0d want %h@%0d", i, {log_q[log_base + i].addr, log_q[log_base + i].data},
                 log_q[log_base + i].cyc, exp_q[i], start_cyc + LAT + i);
      end
    end
    checks++; if (done !== ~exp_err || error !== exp_err) begin errors++; $display("FAIL nominal_end got done %b error %b want %b %b", done, error, ~exp_err, exp_err); end
    if (log_q.size() > log_base) begin
      checks++; if (end_cyc != int'(log_q[log_q.size() - 1].cyc) + 1) begin errors++; $display("FAIL nominal_done_cycle got %0d want %0d", end_cyc, log_q[log_q.size() - 1].cyc + 1); end
    end
  endtask

  task automatic test_backpressure(input int mode, input int base, input int p);
    int v0;
    rdy_mode = mode;
    rdy_base = cyc;
    load_image(base, p, 0);
    model_image(base);
    v0 = stall_viol;
    start_stream(base);
    wait_end(8 * p * 4 + 100);
    checks++; if (timed_out) begin errors++; $display("FAIL bp%0d_timeout got timeout want end", mode); end
    checks++; if (stall_viol != v0) begin errors++; $display("FAIL bp%0d_stall_stable got %0d changes want 0", mode, stall_viol - v0); end
    checks++; if (log_q.size() - log_base != exp_q.size()) begin errors++; $display("FAIL bp%0d_count got %0d want %0d", mode, log_q.size() - log_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++;
      if ({log_q[log_base + i].addr, log_q[log_base + i].data} !== exp_q[i]) begin
        errors++;
        $display("FAIL bp%0d_pkt%0d got %h want %h", mode, i, {log_q[log_base + i].addr, log_q[log_base + i].data}, exp_q[i]);
      end
    end
    checks++; if (done !== ~exp_err || checksum !== exp_sum) begin errors++; $display("FAIL bp%0d_end got done %b sum %h want %b %h", mode, done, checksum, ~exp_err, exp_sum); end
    rdy_mode = 0;
  endtask

  task automatic test_bad_len(input int p);
    load_image(100, p, 0);
    start_stream(100);
    checks++; if (error !== 1'b0 && p == MAXP + 1) begin errors++; $display("FAIL badlen_clear got error %b want 0", error); end
    wait_end(20);
    checks++; if (timed_out || error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL badlen%0d_flags got to %b err %b done %b want 0 1 0", p, timed_out, error, done); end
    checks++; if (end_cyc != start_cyc + LAT) begin errors++; $display("FAIL badlen%0d_cycle got %0d want %0d", p, end_cyc - start_cyc, LAT); end
    repeat (3) @(negedge clk);
    checks++; if (log_q.size() != log_base || busy !== 1'b0) begin errors++; $display("FAIL badlen%0d_packets got %0d busy %b want 0 0", p, log_q.size() - log_base, busy); end
  endtask

  task automatic test_reset_midstream();
    int n;
    rdy_mode = 0;
    load_image(300, 7, 0);
    model_image(300);
    start_stream(300);
    timed_out = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (log_q.size() - log_base >= 11) begin timed_out = 1'b0; break; end
    end
    checks++; if (timed_out) begin errors++; $display("FAIL midreset_reach got timeout want packet 11"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (packet_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_async got valid %b busy %b want 0 0", packet_out_valid, busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = log_q.size();
    repeat (5) @(negedge clk);
    checks++; if (log_q.size() != n || done !== 1'b0) begin errors++; $display("FAIL midreset_quiet got %0d packets done %b want 0 0", log_q.size() - n, done); end
    start_stream(300);
    wait_end(100);
    checks++; if (timed_out || log_q.size() - log_base != exp_q.size()) begin errors++; $display("FAIL midreset_restart got %0d packets want %0d", log_q.size() - log_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++;
      if ({log_q[log_base + i].addr, log_q[log_base + i].data} !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_pkt%0d got %h want %h", i, {log_q[log_base + i].addr, log_q[log_base + i].data}, exp_q[i]);
      end
    end
  endtask

  task automatic test_start_during_body();
    rdy_mode = 0;
    load_image(500, 7, 0);
    load_image(900, 2, 0);
    model_image(500);
    start_stream(500);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (log_q.size() - log_base >= 6) break;
    end
    @(posedge clk); #1;
    image_base = AW'(900);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(100);
    checks++; if (timed_out || done !== 1'b1 || log_q.size() - log_base != exp_q.size()) begin errors++; $display("FAIL midstart_count got %0d done %b want %0d 1", log_q.size() - log_base, done, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++;
      if ({log_q[log_base + i].addr, log_q[log_base + i].data} !== exp_q[i]) begin
        errors++;
        $display("FAIL midstart_pkt%0d got %h want %h", i, {log_q[log_base + i].addr, log_q[log_base + i].data}, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    load_image(700, 3, 0);
    model_image(700);
    start_stream(700);
    checks++; if (done !== 1'b0 || busy !== 1'b1 || checksum !== '0) begin errors++; $display("FAIL b2b_clear got done %b busy %b sum %h want 0 1 0", done, busy, checksum); end
    wait_end(60);
    checks++; if (timed_out || log_q.size() - log_base != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", log_q.size() - log_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++;
      if ({log_q[log_base + i].addr, log_q[log_base + i].data} !== exp_q[i] ||
          int'(log_q[log_base + i].cyc) != start_cyc + LAT + i) begin
        errors++;
        $display("FAIL b2b_pkt%0d got %h@%0d want %h@%0d", i, {log_q[log_base + i].addr, log_q[log_base + i].data},
                 log_q[log_base + i].cyc, exp_q[i], start_cyc + LAT + i);
      end
    end
  endtask

  task automatic test_checksum(input int off);
    rdy_mode = 0;
    load_image(1200, 7, off);
    model_image(1200);
    start_stream(1200);
    wait_end(100);
    repeat (2) @(negedge clk);
`ifdef BOOT_IMAGE_STREAMER_CHECKSUM_EN
    checks++; if (error !== (off != 0) || done !== (off == 0)) begin errors++; $display("FAIL sum%0d_flags got err %b done %b want %b %b", off, error, done, off != 0, off == 0); end
    checks++; if (log_q.size() - log_base != ((off != 0) ? 29 : 32)) begin errors++; $display("FAIL sum%0d_count got %0d want %0d", off, log_q.size() - log_base, (off != 0) ? 29 : 32); end
`else
    checks++; if (error !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL sum%0d_flags got err %b done %b want 0 1", off, error, done); end
    checks++; if (log_q.size() - log_base != 32) begin errors++; $display("FAIL sum%0d_count got %0d want 32", off, log_q.size() - log_base); end
`endif
    checks++; if (checksum !== exp_sum) begin errors++; $display("FAIL sum%0d_value got %h want %h", off, checksum, exp_sum); end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++;
      if ({log_q[log_base + i].addr, log_q[log_base + i].data} !== exp_q[i]) begin
        errors++;
        $display("FAIL sum%0d_pkt%0d got %h want %h", off, i, {log_q[log_base + i].addr, log_q[log_base + i].data}, exp_q[i]);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_nominal();
    test_backpressure(1, 0, 7);
    test_backpressure(2, 2040 + $urandom_range(0, 7), $urandom_range(1, 20));
    test_backpressure(0, 0, MAXP);
    test_bad_len(0);
    test_bad_len(MAXP + 1);
    test_reset_midstream();
    test_start_during_body();
    test_back_to_back();
    test_checksum(0);
    test_checksum(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
